// File: rtl/bcd_chain_counter_if.sv
// Control and data bundle for the BCD chain counter.
// The master side (timer/game controller) drives the requests; the slave
// side (the counter) drives back the packed digits and status flags.
interface bcd_chain_counter_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      clear;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   load_val;
    logic                      tick;
    logic                      up;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic                      tc;
    logic                      locked;
    logic                      at_zero;

    modport master (
        output clear, load, load_val, tick, up,
        input  digits, tc, locked, at_zero
    );

    modport slave (
        input  clear, load, load_val, tick, up,
        output digits, tc, locked, at_zero
    );
endinterface

// File: rtl/bcd_chain_counter.sv
// Multi-digit packed BCD up/down counter with parallel load, clear and a
// choice of wrap or saturate-and-lock behaviour at the count limits.
// Digit 0 is the least significant nibble of the packed bus.
module bcd_chain_counter #(
    parameter int NUM_DIGITS = 4,
    parameter bit WRAP       = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_chain_counter_if.slave   bus
);
    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic {
        RUN    = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   digits_q, digits_d;
    logic           tc_q, tc_d;
    logic           at_zero_q, at_zero_d;

    logic [W-1:0]   inc_val;
    logic [W-1:0]   dec_val;
    logic [W-1:0]   clamp_val;
    logic           all_nines;
    logic           all_zeros;

    // Ripple the increment carry and decrement borrow across the digits and
    // clamp each load nibble into the 0..9 range. An incremented all-9s value
    // naturally becomes all-0s and a decremented all-0s becomes all-9s,
    // which is exactly the wrap result.
    always_comb begin : chain
        logic carry_run;
        logic borrow_run;
        carry_run  = 1'b1;
        borrow_run = 1'b1;
        inc_val    = digits_q;
        dec_val    = digits_q;
        clamp_val  = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (carry_run) begin
                inc_val[4*i +: 4] = (digits_q[4*i +: 4] == 4'd9) ? 4'd0
                                                                 : digits_q[4*i +: 4] + 4'd1;
            end
            if (borrow_run) begin
                dec_val[4*i +: 4] = (digits_q[4*i +: 4] == 4'd0) ? 4'd9
                                                                 : digits_q[4*i +: 4] - 4'd1;
            end
            carry_run  = carry_run  && (digits_q[4*i +: 4] == 4'd9);
            borrow_run = borrow_run && (digits_q[4*i +: 4] == 4'd0);
            clamp_val[4*i +: 4] = (bus.load_val[4*i +: 4] > 4'd9) ? 4'd9
                                                                   : bus.load_val[4*i +: 4];
        end
        all_nines = carry_run;
        all_zeros = borrow_run;
    end

    // Next-state decision: clear beats load beats tick; ticks only count in
    // RUN, and a tick made while already at the limit pulses tc and either
    // wraps or parks the counter in LOCKED.
    always_comb begin
        state_d  = state_q;
        digits_d = digits_q;
        tc_d     = 1'b0;
        if (bus.clear) begin
            digits_d = '0;
            state_d  = RUN;
        end else if (bus.load) begin
            digits_d = clamp_val;
            state_d  = RUN;
        end else if (bus.tick && (state_q == RUN)) begin
            if (bus.up) begin
                if (all_nines) begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        digits_d = inc_val;
                    end else begin
                        state_d = LOCKED;
                    end
                end else begin
                    digits_d = inc_val;
                end
            end else begin
                if (all_zeros) begin
                    tc_d = 1'b1;
                    if (WRAP) begin
                        digits_d = dec_val;
                    end else begin
                        state_d = LOCKED;
                    end
                end else begin
                    digits_d = dec_val;
                end
            end
        end
        at_zero_d = (digits_d == '0);
    end

    // State, count and status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= RUN;
            digits_q  <= '0;
            tc_q      <= 1'b0;
            at_zero_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            digits_q  <= digits_d;
            tc_q      <= tc_d;
            at_zero_q <= at_zero_d;
        end
    end

    assign bus.digits  = digits_q;
    assign bus.tc      = tc_q;
    assign bus.locked  = (state_q == LOCKED);
    assign bus.at_zero = at_zero_q;
endmodule

// File: tb/tb_bcd_chain_counter.sv
// Scoreboard bench for bcd_chain_counter: a saturating 4-digit instance and
// a wrapping 2-digit instance driven with directed vectors.
module tb_bcd_chain_counter;
    logic clk;
    logic rst;

    bcd_chain_counter_if #(.NUM_DIGITS(4)) if_a ();
    bcd_chain_counter_if #(.NUM_DIGITS(2)) if_b ();

    bcd_chain_counter #(.NUM_DIGITS(4), .WRAP(1'b0)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    bcd_chain_counter #(.NUM_DIGITS(2), .WRAP(1'b1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    typedef struct {
        bit          sel_b;
        logic [15:0] dig;
        logic        tc;
        logic        locked;
        logic        at_zero;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] exp_val;

    localparam bit A = 1'b0;
    localparam bit B = 1'b1;

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs to the selected instance and queue the
    // response expected after the following rising edge.
    task automatic applyStimulus(input bit sel_b, input logic r, input logic c,
                                 input logic l, input logic [15:0] lv,
                                 input logic t, input logic u,
                                 input logic [15:0] ed, input logic etc,
                                 input logic el, input logic ez, input string nm);
        exp_t e;
        @(negedge clk);
        rst = r;
        if_a.clear = 1'b0; if_a.load = 1'b0; if_a.tick = 1'b0; if_a.up = 1'b0;
        if_b.clear = 1'b0; if_b.load = 1'b0; if_b.tick = 1'b0; if_b.up = 1'b0;
        if (sel_b) begin
            if_b.clear = c; if_b.load = l; if_b.load_val = lv[7:0];
            if_b.tick  = t; if_b.up   = u;
        end else begin
            if_a.clear = c; if_a.load = l; if_a.load_val = lv;
            if_a.tick  = t; if_a.up   = u;
        end
        @(posedge clk);
        e.sel_b = sel_b; e.dig = ed; e.tc = etc; e.locked = el; e.at_zero = ez; e.name = nm;
        sb.push_back(e);
    endtask

    // Compare one expected entry against the selected instance's outputs.
    task automatic checkOutput(input exp_t e);
        logic [18:0] act;
        logic [18:0] req;
        if (e.sel_b) act = {8'h00, if_b.digits, if_b.tc, if_b.locked, if_b.at_zero};
        else         act = {if_a.digits, if_a.tc, if_a.locked, if_a.at_zero};
        req = {e.dig, e.tc, e.locked, e.at_zero};
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("[TB] FAIL %s: got digits=%h tc=%b locked=%b at_zero=%b, want digits=%h tc=%b locked=%b at_zero=%b",
                     e.name, act[18:3], act[2], act[1], act[0], req[18:3], req[2], req[1], req[0]);
        end
    endtask

    // Monitor: every falling edge, consume one pending expectation.
    always @(negedge clk) begin
        if (sb.size() > 0) checkOutput(sb.pop_front());
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        if_a.clear = 1'b0; if_a.load = 1'b0; if_a.load_val = '0; if_a.tick = 1'b0; if_a.up = 1'b0;
        if_b.clear = 1'b0; if_b.load = 1'b0; if_b.load_val = '0; if_b.tick = 1'b0; if_b.up = 1'b0;

        // Reset state on both instances.
        applyStimulus(A, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1, "reset_a");
        applyStimulus(B, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1, "reset_b");

        // Twelve up ticks from zero.
        for (int k = 1; k <= 12; k++) begin
            exp_val = (k < 10) ? 16'(k) : 16'h0010 + 16'(k - 10);
            applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, exp_val, 0, 0, 0, "count_up");
        end

        // Wrapping instance: up and down through the limits.
        applyStimulus(B, 1, 0, 1, 16'h0098, 0, 0, 16'h0098, 0, 0, 0, "wrap_load98");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 1, 16'h0099, 0, 0, 0, "wrap_up99");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 1, "wrap_up00");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0, 0, "wrap_up01");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, "wrap_dn00");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 0, 16'h0099, 1, 0, 0, "wrap_dn99");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 0, 16'h0098, 0, 0, 0, "wrap_dn98");
        applyStimulus(B, 1, 0, 1, 16'h0099, 0, 0, 16'h0099, 0, 0, 0, "wrap_load99");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 1, 0, 1, "wrap_tc_first");
        applyStimulus(B, 1, 0, 0, 16'h0000, 1, 0, 16'h0099, 1, 0, 0, "wrap_tc_second");

        // Down saturation and lock.
        applyStimulus(A, 1, 0, 1, 16'h0001, 0, 0, 16'h0001, 0, 0, 0, "sat_load01");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 1, "sat_dn_to0");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 1, 1, 1, "sat_dn_lock");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 1, 1, "sat_dn_held");
        for (int k = 0; k < 5; k++)
            applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 1, 1, "sat_up_ignored");
        applyStimulus(A, 1, 1, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1, "sat_clear_unlock");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0, 0, "sat_up_after_clear");

        // Up saturation, then load exits lock.
        applyStimulus(A, 1, 0, 1, 16'h9999, 0, 0, 16'h9999, 0, 0, 0, "sat_load9999");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h9999, 1, 1, 0, "sat_up_lock");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h9999, 0, 1, 0, "sat_up_held");
        applyStimulus(A, 1, 0, 1, 16'h0007, 1, 1, 16'h0007, 0, 0, 0, "locked_load07");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h0008, 0, 0, 0, "locked_load_up");

        // Load clamping and borrow.
        applyStimulus(A, 1, 0, 1, 16'hA3F5, 0, 0, 16'h9395, 0, 0, 0, "clamp_load");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 0, 16'h9394, 0, 0, 0, "clamp_dn");
        applyStimulus(A, 1, 0, 1, 16'h1000, 0, 0, 16'h1000, 0, 0, 0, "borrow_load");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 0, 16'h0999, 0, 0, 0, "borrow_dn");

        // Priority between clear, load and tick.
        applyStimulus(A, 1, 1, 1, 16'h0042, 1, 1, 16'h0000, 0, 0, 1, "prio_clear");
        applyStimulus(A, 1, 0, 1, 16'h0042, 1, 1, 16'h0042, 0, 0, 0, "prio_load");

        // Direction mix and reset in the middle of a tick burst.
        applyStimulus(A, 1, 0, 1, 16'h0100, 0, 0, 16'h0100, 0, 0, 0, "mix_load100");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 0, 16'h0099, 0, 0, 0, "mix_dn");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h0100, 0, 0, 0, "mix_up");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h0101, 0, 0, 0, "mix_up2");
        applyStimulus(A, 0, 0, 0, 16'h0000, 1, 1, 16'h0000, 0, 0, 1, "mid_reset");
        applyStimulus(A, 1, 0, 0, 16'h0000, 1, 1, 16'h0001, 0, 0, 0, "after_reset");

        // Idle and let the monitor drain the queue.
        @(negedge clk);
        if_a.tick = 1'b0; if_b.tick = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain: %0d expectations left, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
